// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared game constants and the spawn scheduler state type.
package enemy_spawn_scheduler_pkg;

    localparam int NUM_SLOTS    = 6;
    localparam int X_MAX        = 608;
    localparam int SCREEN_WIDTH = 640;
    localparam int X_W          = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SELECT,
        ISSUE
    } spawn_state_t;

    function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] x,
                                               input logic [X_W-1:0] xmax);
        return (x > xmax) ? xmax : x;
    endfunction

endpackage

// File: rtl/enemy_spawn_scheduler_rr.sv
// Round-robin search for the first set bit of mask, starting at start and wrapping.
module rr_free_finder #(
    parameter int N  = 6,
    parameter int IW = 3
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] index
);

    int          pos;
    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = 0;
        cand  = '0;
        // Scan backwards so the candidate nearest to start is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IW'(pos);
            if (mask[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: periodic round-robin slot allocation with difficulty ramp.
module enemy_spawn_scheduler #(
    parameter int NUM_SLOTS    = enemy_spawn_scheduler_pkg::NUM_SLOTS,
    parameter int PERIOD_INIT  = 90,
    parameter int PERIOD_MIN   = 20,
    parameter int PERIOD_STEP  = 5,
    parameter int LEVEL_SPAWNS = 8,
    parameter int X_MAX        = enemy_spawn_scheduler_pkg::X_MAX
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 enable,
    input  logic [9:0]           random0,
    input  logic [9:0]           random1,
    input  logic [9:0]           random2,
    input  logic [9:0]           random3,
    input  logic [9:0]           random4,
    input  logic [9:0]           random5,
    input  logic [NUM_SLOTS-1:0] kill,
    input  logic                 spawn_ready,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_slot,
    output logic [9:0]           spawn_x,
    output logic [NUM_SLOTS-1:0] active,
    output logic [3:0]           level,
    output logic                 missed
);

    import enemy_spawn_scheduler_pkg::*;

    localparam int PW = 16;
    localparam int IW = 3;
    localparam int CW = $clog2(LEVEL_SPAWNS + 1);

    spawn_state_t state_reg, state_next;

    logic [PW-1:0]        tick_cnt_reg, period_reg, period_dec;
    logic [CW-1:0]        spawn_cnt_reg;
    logic [IW-1:0]        rr_ptr_reg, sel_reg, found_idx, slot_reg;
    logic [NUM_SLOTS-1:0] active_reg, active_next, set_mask;
    logic [3:0]           level_reg;
    logic [X_W-1:0]       x_reg;
    logic                 valid_reg, missed_reg, found;
    logic                 tick_clr, tick_inc, take_sel, miss_now, handshake;

    logic [9:0] random_all [6];
    logic [9:0] random_arr [NUM_SLOTS];

    assign random_all[0] = random0;
    assign random_all[1] = random1;
    assign random_all[2] = random2;
    assign random_all[3] = random3;
    assign random_all[4] = random4;
    assign random_all[5] = random5;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_rand
            assign random_arr[gi] = random_all[gi];
        end
    endgenerate

    rr_free_finder #(.N(NUM_SLOTS), .IW(IW)) u_finder (
        .mask  (~active_reg),
        .start (rr_ptr_reg),
        .found (found),
        .index (found_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tick_clr   = 1'b0;
        tick_inc   = 1'b0;
        take_sel   = 1'b0;
        miss_now   = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT;
                    tick_clr   = 1'b1;
                end
            end
            WAIT: begin
                if (tick && enable) begin
                    if (tick_cnt_reg == period_reg - PW'(1)) begin
                        state_next = SELECT;
                        tick_clr   = 1'b1;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            SELECT: begin
                if (found) begin
                    take_sel   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    miss_now   = 1'b1;
                    state_next = WAIT;
                end
            end
            ISSUE: begin
                if (spawn_ready) begin
                    handshake  = 1'b1;
                    state_next = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The handshake set is OR-ed after the kill mask, so a same-cycle kill on sel loses.
    always_comb begin
        set_mask = '0;
        if (handshake) begin
            set_mask[sel_reg] = 1'b1;
        end
        active_next = (active_reg & ~kill) | set_mask;
    end

    assign period_dec = (period_reg >= PW'(PERIOD_MIN + PERIOD_STEP)) ?
                        period_reg - PW'(PERIOD_STEP) : PW'(PERIOD_MIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_reg  <= '0;
            spawn_cnt_reg <= '0;
            rr_ptr_reg    <= '0;
            sel_reg       <= '0;
            period_reg    <= PW'(PERIOD_INIT);
            level_reg     <= '0;
            active_reg    <= '0;
            valid_reg     <= 1'b0;
            slot_reg      <= '0;
            x_reg         <= '0;
            missed_reg    <= 1'b0;
        end else begin
            missed_reg <= miss_now;
            active_reg <= active_next;
            if (tick_clr) begin
                tick_cnt_reg <= '0;
            end else if (tick_inc) begin
                tick_cnt_reg <= tick_cnt_reg + PW'(1);
            end
            if (take_sel) begin
                sel_reg   <= found_idx;
                slot_reg  <= found_idx;
                x_reg     <= clamp_x(random_arr[found_idx], X_W'(X_MAX));
                valid_reg <= 1'b1;
            end
            if (handshake) begin
                valid_reg  <= 1'b0;
                rr_ptr_reg <= (sel_reg == IW'(NUM_SLOTS - 1)) ? '0 : sel_reg + IW'(1);
                if (spawn_cnt_reg == CW'(LEVEL_SPAWNS - 1)) begin
                    spawn_cnt_reg <= '0;
                    period_reg    <= period_dec;
                    if (level_reg != 4'd15) begin
                        level_reg <= level_reg + 4'd1;
                    end
                end else begin
                    spawn_cnt_reg <= spawn_cnt_reg + CW'(1);
                end
            end
        end
    end

    assign spawn_valid = valid_reg;
    assign spawn_slot  = slot_reg;
    assign spawn_x     = x_reg;
    assign active      = active_reg;
    assign level       = level_reg;
    assign missed      = missed_reg;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Bench for enemy_spawn_scheduler: directed vector table, corner sequences, random vs. model.
module tb_enemy_spawn_scheduler;

    localparam int INIT_A = 3;
    localparam int MIN_A  = 1;
    localparam int STEP_A = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic       spawn_ready = 1'b0;
    logic [5:0] kill = '0;
    logic [9:0] rnd [6];

    logic       a_valid, b_valid, a_missed, b_missed;
    logic [2:0] a_slot, b_slot;
    logic [9:0] a_x, b_x;
    logic [5:0] a_active, b_active;
    logic [3:0] a_level, b_level;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    enemy_spawn_scheduler #(.PERIOD_INIT(INIT_A), .PERIOD_MIN(MIN_A), .PERIOD_STEP(STEP_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .tick(tick), .enable(enable),
        .random0(rnd[0]), .random1(rnd[1]), .random2(rnd[2]),
        .random3(rnd[3]), .random4(rnd[4]), .random5(rnd[5]),
        .kill(kill), .spawn_ready(spawn_ready),
        .spawn_valid(a_valid), .spawn_slot(a_slot), .spawn_x(a_x),
        .active(a_active), .level(a_level), .missed(a_missed)
    );

    enemy_spawn_scheduler dut_b (
        .clk(clk), .reset_n(reset_n), .tick(tick), .enable(enable),
        .random0(rnd[0]), .random1(rnd[1]), .random2(rnd[2]),
        .random3(rnd[3]), .random4(rnd[4]), .random5(rnd[5]),
        .kill(kill), .spawn_ready(spawn_ready),
        .spawn_valid(b_valid), .spawn_slot(b_slot), .spawn_x(b_x),
        .active(b_active), .level(b_level), .missed(b_missed)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at a falling edge; inputs are held through the next rising edge.
    task automatic step(input logic tk, input logic en, input logic [5:0] kl, input logic rdy);
        tick        = tk;
        enable      = en;
        kill        = kl;
        spawn_ready = rdy;
        @(negedge clk);
    endtask

    task automatic set_rnd();
        rnd[0] = 10'd200; rnd[1] = 10'd700; rnd[2] = 10'd100;
        rnd[3] = 10'd300; rnd[4] = 10'd1000; rnd[5] = 10'd500;
    endtask

    // Reference model: what the block's outputs should be after the next edge.
    int         m_mode, m_tcnt, m_period, m_scnt, m_lvl, m_rr, m_sel, m_slot, m_x;
    logic       m_vld, m_mis;
    logic [5:0] m_act;

    task automatic model_reset();
        m_mode = 0; m_tcnt = 0; m_period = INIT_A; m_scnt = 0; m_lvl = 0;
        m_rr = 0; m_sel = 0; m_slot = 0; m_x = 0; m_vld = 1'b0; m_mis = 1'b0; m_act = '0;
    endtask

    task automatic model_step(input logic tk, input logic en, input logic [5:0] kl, input logic rdy);
        logic [5:0] act_n;
        bit         got;
        int         p;
        act_n = m_act & ~kl;
        m_mis = 1'b0;
        got   = 1'b0;
        case (m_mode)
            0: if (en) begin m_mode = 1; m_tcnt = 0; end
            1: if (tk && en) begin
                   if (m_tcnt == m_period - 1) begin m_mode = 2; m_tcnt = 0; end
                   else m_tcnt++;
               end
            2: begin
                   for (int k = 0; k < 6; k++) begin
                       p = (m_rr + k) % 6;
                       if (!got && !m_act[p]) begin got = 1'b1; m_sel = p; end
                   end
                   if (got) begin
                       m_mode = 3; m_vld = 1'b1; m_slot = m_sel;
                       m_x = (int'(rnd[m_sel]) > 608) ? 608 : int'(rnd[m_sel]);
                   end else begin
                       m_mis = 1'b1; m_mode = 1;
                   end
               end
            default: if (rdy) begin
                   act_n[m_sel] = 1'b1;
                   m_rr = (m_sel + 1) % 6; m_vld = 1'b0; m_mode = 1;
                   m_scnt++;
                   if (m_scnt == 8) begin
                       m_scnt = 0;
                       if (m_lvl < 15) m_lvl++;
                       m_period = (m_period - STEP_A < MIN_A) ? MIN_A : m_period - STEP_A;
                   end
               end
        endcase
        m_act = act_n;
    endtask

    typedef struct {
        logic       tk;
        logic       en;
        logic [5:0] kl;
        logic       rdy;
        logic       vld;
        int         slot;
        int         x;
        logic [5:0] act;
        logic       mis;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Inputs applied during one cycle, then outputs expected after that edge.
        tbl[0]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h00, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h00, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b1, 0, 200, 6'h00, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h01, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h01, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h01, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h01, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b1, 1, 608, 6'h01, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 6'h00, 1'b1, 1'b0, 0, 0,   6'h03, 1'b0};

        set_rnd();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        chk("rst_valid", a_valid, 0);
        chk("rst_slot", a_slot, 0);
        chk("rst_x", a_x, 0);
        chk("rst_active", a_active, 0);
        chk("rst_level", a_level, 0);
        chk("rst_missed", a_missed, 0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].tk, tbl[i].en, tbl[i].kl, tbl[i].rdy);
            chk("tbl_valid", a_valid, tbl[i].vld);
            chk("tbl_active", a_active, tbl[i].act);
            chk("tbl_missed", a_missed, tbl[i].mis);
            if (tbl[i].vld) begin
                chk("tbl_slot", a_slot, tbl[i].slot);
                chk("tbl_x", a_x, tbl[i].x);
            end
            $display("row %0d: valid=%0b slot=%0d x=%0d active=%b", i, a_valid, a_slot, a_x, a_active);
        end

        // Fill the remaining slots in round-robin order.
        begin
            int want;
            int guard;
            want  = 2;
            guard = 0;
            while (a_active != 6'h3f && guard < 60) begin
                step(1'b1, 1'b1, 6'h00, 1'b1);
                guard++;
                if (a_valid && want < 6) begin
                    chk("fill_slot", a_slot, want);
                    chk("fill_x", a_x, (rnd[want] > 10'd608) ? 608 : int'(rnd[want]));
                    $display("fill spawn: slot=%0d x=%0d", a_slot, a_x);
                    want++;
                end
            end
            chk("fill_done", a_active, 6'h3f);
        end

        // Expiry with every slot occupied, twice, to show the tick count restarts.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1, 1'b1, 6'h00, 1'b1);
                chk("miss_quiet", a_missed, 0);
                chk("miss_novalid", a_valid, 0);
            end
            step(1'b1, 1'b1, 6'h00, 1'b1);
            chk("miss_pulse", a_missed, 1);
            chk("miss_novalid", a_valid, 0);
            $display("miss %0d: missed=%0b valid=%0b", r, a_missed, a_valid);
        end

        step(1'b0, 1'b1, 6'h08, 1'b1);
        chk("kill3_active", a_active, 6'h37);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 6'h00, 1'b1);
            chk("kill3_wait", a_valid, 0);
        end
        step(1'b1, 1'b1, 6'h00, 1'b1);
        chk("kill3_valid", a_valid, 1);
        chk("kill3_slot", a_slot, 3);
        chk("kill3_x", a_x, 300);
        step(1'b0, 1'b1, 6'h00, 1'b1);
        chk("kill3_refill", a_active, 6'h3f);
        $display("respawn: active=%b", a_active);

        // Stalled issue: outputs hold while randoms churn; another slot is killed meanwhile.
        step(1'b0, 1'b1, 6'h05, 1'b0);
        chk("stall_pre", a_active, 6'h3a);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 6'h00, 1'b0);
        end
        chk("stall_valid0", a_valid, 1);
        chk("stall_slot0", a_slot, 0);
        chk("stall_x0", a_x, 200);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 6; j++) rnd[j] = 10'($urandom_range(0, 1023));
            step(1'b1, 1'b1, (i == 4) ? 6'h02 : 6'h00, 1'b0);
            chk("stall_valid", a_valid, 1);
            chk("stall_slot", a_slot, 0);
            chk("stall_x", a_x, 200);
        end
        chk("stall_kill", a_active, 6'h38);
        set_rnd();
        step(1'b0, 1'b1, 6'h01, 1'b1);
        chk("hs_setwins", a_active, 6'h39);
        chk("hs_drop", a_valid, 0);
        chk("hs_level", a_level, 1);
        $display("stall done: active=%b level=%0d", a_active, a_level);

        // Asynchronous reset in the middle of an issue (period is now 2, next slot 1).
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 6'h00, 1'b0);
        end
        chk("ar_valid_pre", a_valid, 1);
        chk("ar_slot_pre", a_slot, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", a_valid, 0);
        chk("ar_active", a_active, 0);
        chk("ar_level", a_level, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 6'h00, 1'b1);
            chk("ar_idle", a_valid, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 6'h00, 1'b1);
            chk("ar_restart", a_valid, (i == 4) ? 1 : 0);
        end
        chk("ar_slot", a_slot, 0);
        step(1'b0, 1'b1, 6'h00, 1'b1);
        chk("ar_active_after", a_active, 6'h01);
        $display("post-reset spawn: active=%b", a_active);

        // Random stimulus against the model.
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2500; c++) begin
            logic       tk, en, rdy;
            logic [5:0] kl;
            tk  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < 6; j++) begin
                kl[j]  = ($urandom_range(0, 9) == 0);
                rnd[j] = 10'($urandom_range(0, 1023));
            end
            model_step(tk, en, kl, rdy);
            step(tk, en, kl, rdy);
            chk("rnd_valid", a_valid, m_vld);
            chk("rnd_active", a_active, m_act);
            chk("rnd_missed", a_missed, m_mis);
            chk("rnd_level", a_level, m_lvl);
            if (m_vld) begin
                chk("rnd_slot", a_slot, m_slot);
                chk("rnd_x", a_x, m_x);
            end
        end
        $display("random run: level=%0d active=%b", a_level, a_active);

        // Difficulty ramp on the default-parameter instance, seen via spawn spacing.
        set_rnd();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int last;
            int nsp;
            int cyc;
            int per;
            last = -1;
            nsp  = 0;
            cyc  = 0;
            while (nsp < 128 && cyc < 20000) begin
                step(1'b1, 1'b1, 6'h3f, 1'b1);
                cyc++;
                if (b_valid) begin
                    per = 90 - 5 * (nsp / 8);
                    if (per < 20) per = 20;
                    if (last >= 0) chk("ramp_interval", cyc - last, per + 2);
                    chk("ramp_level", b_level, (nsp / 8 > 15) ? 15 : nsp / 8);
                    if (nsp % 8 == 0) $display("spawn %0d: level=%0d period=%0d", nsp, b_level, per);
                    last = cyc;
                    nsp++;
                end
            end
            chk("ramp_count", nsp, 128);
            step(1'b0, 1'b1, 6'h00, 1'b1);
            chk("ramp_sat", b_level, 15);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enemy_spawn_scheduler.md
ENEMY_SPAWN_SCHEDULER -- requirements
Module: enemy_spawn_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 6: number of enemy object slots; each slot is paired with one random input.
REQ-002 Parameter PERIOD_INIT, default 90: initial spawn period, in frame ticks.
REQ-003 Parameter PERIOD_MIN, default 20: floor for the spawn period, in ticks.
REQ-004 Parameter PERIOD_STEP, default 5: amount the period decreases at each level-up, in ticks.
REQ-005 Parameter LEVEL_SPAWNS, default 8: number of successful spawns per level-up.
REQ-006 Parameter X_MAX, default 608: largest legal spawn x coordinate.
REQ-007 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-008 Port list; all ports are synchronous to clk unless stated:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- tick, input, 1: one-cycle pulse per video frame.
- enable, input, 1: game running.
- random0..random5, input, 10 each: pseudo-random x candidates.
- kill, input, NUM_SLOTS: one-cycle per-slot pulse; the enemy in that slot is destroyed or has left the screen.
- spawn_ready, input, 1: the slot object accepts a spawn.
- spawn_valid, output, 1: spawn request pending.
- spawn_slot, output, 3: target slot index.
- spawn_x, output, 10: spawn x coordinate.
- active, output, NUM_SLOTS: slot-occupied mask.
- level, output, 4: difficulty level.
- missed, output, 1: one-cycle pulse; a period expired while all slots were occupied.

Function
REQ-009 The FSM SHALL have four states: IDLE, WAIT, SELECT, ISSUE.
REQ-010 IDLE SHALL go to WAIT when enable=1, loading tick_cnt=0.
REQ-011 In WAIT, each tick with enable=1 SHALL increment tick_cnt; a tick with tick_cnt==period_cur-1 SHALL go to SELECT and clear tick_cnt. A tick with enable=0 SHALL not count; tick_cnt holds.
REQ-012 In WAIT, enable=0 SHALL not change state; tick_cnt SHALL hold.
REQ-013 SELECT SHALL take exactly one cycle. It searches ~active round-robin, starting at rr_ptr.
- Free slot found: record it as sel and go to ISSUE.
- All slots occupied: pulse missed and return to WAIT.
REQ-014 On entry to ISSUE, the block SHALL register spawn_slot=sel and spawn_x=min(random[sel], X_MAX). spawn_valid SHALL be 1 for the whole of ISSUE.
REQ-015 spawn_valid, spawn_slot and spawn_x SHALL stay stable until spawn_valid && spawn_ready. The handshake SHALL complete regardless of enable.
REQ-016 Handshake completion (one cycle) SHALL perform all of the following, then return to WAIT:
- set active[sel];
- rr_ptr = (sel+1) mod NUM_SLOTS;
- increment spawn_cnt;
- deassert spawn_valid in the next cycle.
REQ-017 Minimum issue latency SHALL be 2 cycles from the expiring tick to spawn_valid=1. With spawn_ready held at 1, active SHALL update on the 3rd cycle.
REQ-018 kill[i] SHALL clear active[i] on the next edge, in any state. A kill on the slot being issued in the handshake cycle SHALL lose; the set wins. A kill on an already-clear slot SHALL be ignored.
REQ-019 When spawn_cnt reaches LEVEL_SPAWNS, the following SHALL occur:
- spawn_cnt SHALL wrap to 0;
- level SHALL increment, saturating at 15;
- period_cur SHALL become max(period_cur-PERIOD_STEP, PERIOD_MIN), computed without underflow.
REQ-020 Deasserting enable SHALL never clear active, level or period_cur.

Reset
REQ-021 On reset_n=0, asynchronously:
- state=IDLE;
- tick_cnt=0, spawn_cnt=0, rr_ptr=0, sel=0;
- period_cur=PERIOD_INIT, level=0, active=0;
- spawn_valid=0, spawn_slot=0, spawn_x=0, missed=0.
REQ-022 Reset asserted mid-ISSUE SHALL drop spawn_valid immediately, without waiting for a clock edge. No slot SHALL become active.

Structure
REQ-023 The shared game package SHALL hold the following:
- the FSM state enum;
- NUM_SLOTS;
- X_MAX;
- the screen width constant.
REQ-024 The round-robin free-slot finder SHALL be a purely combinational sub-module, rr_free_finder. Inputs: mask and start pointer. Outputs: found and index.
REQ-025 The random inputs SHALL be indexed internally as a NUM_SLOTS-entry array.

Verification
REQ-026 Reset, enable=1, PERIOD_INIT=3, spawn_ready=1, random0=200 -> after the 3rd tick: spawn_valid=1, slot 0, x=200 for one cycle; active=000001.
REQ-027 random1=700, slot 1 next -> spawn_x=608, i.e. X_MAX clamp.
REQ-028 active=111111 at period expiry -> missed pulses 1 cycle, spawn_valid stays 0, tick_cnt restarts; then kill[3] -> next expiry spawns slot 3.
REQ-029 spawn_ready=0 for 10 cycles during ISSUE, random inputs changing -> spawn_slot and spawn_x stable, spawn_valid held; kill on another slot clears that slot meanwhile.
REQ-030 Run 8 spawns with PERIOD_INIT=90 -> level=1, period_cur=85. Keep going until period_cur=20 -> the next level-up holds period_cur at 20.
REQ-031 reset_n low mid-ISSUE -> spawn_valid=0 immediately, active=0, state IDLE after release.
